pic_fetch_unit: RTL and testbench
=================================

# pic_fetch_unit

Program-counter and instruction-fetch stage of the PIC16F-compatible core, directly upstream of the instruction decoder. It holds the 13-bit PC, drives the program-memory address, and captures the fetched 14-bit word into the instruction register presented to the decoder as `instr_current`. It also provides the 8-level hardware return stack for CALL/RETURN and the branch flush (forced NOP). It acts only on strobes issued by the decoder in its Q-cycle sequence.

## Interface
- No parameters. Widths are fixed by the ISA.
- `clk` in 1 — sole clock, rising edge.
- `rst` in 1 — synchronous, active-low reset (`rst`=0 at a rising edge resets).
- `prog_addr` out 13 — program-memory address, always equal to PC.
- `prog_rd_data` in 14 — program-memory word; combinational read of `prog_addr`.
- `instr_rd_en` in 1 — capture `prog_rd_data` into IR.
- `incr_pc_en` in 1 — PC ← PC+1.
- `flush_en` in 1 — IR ← 14'h0000 (NOP).
- `pc_load_en` in 1 — PC ← `pc_load_val` (GOTO/CALL target).
- `pc_load_val` in 13 — target, pre-assembled by the decoder as {PCLATH[4:3], k[10:0]}.
- `pcl_wr_en` in 1 — write to the PCL register.
- `pcl_wr_data` in 8 — new PCL value.
- `pclath` in 5 — current PCLATH register contents.
- `stack_push_en` in 1 — push the current PC.
- `stack_pop_en` in 1 — PC ← top of stack; pop.
- `instr_current` out 14 — IR contents, to the decoder.
- `stack_overflow` out 1 — sticky overflow flag (see Configuration).
- `stack_underflow` out 1 — sticky underflow flag (see Configuration).

## Operation
- Reset values:
  - PC = 13'h0000; IR = 14'h0000 (NOP).
  - Stack pointer = 0; all 8 stack entries = 0.
  - `stack_overflow` = `stack_underflow` = 0.
- IR update priority: `flush_en` > `instr_rd_en` > hold.
- PC update priority, highest first:
  - `stack_pop_en`: PC ← stack[sp−1].
  - `pc_load_en`: PC ← `pc_load_val`.
  - `pcl_wr_en`: PC ← {`pclath`, `pcl_wr_data`}.
  - `incr_pc_en`: PC ← PC+1.
  - Otherwise PC holds.
- PC arithmetic is 13-bit modulo: 13'h1FFF + 1 = 13'h0000.
- Push:
  - stack[sp] ← PC, using the register value before this edge's PC update.
  - sp ← sp+1 mod 8.
  - Push and `pc_load_en` in the same cycle is a CALL: the old PC is pushed and the target is loaded.
- Pop: sp ← sp−1 mod 8.
- Push and pop in the same cycle: the pop wins, the push is ignored, and sp is decremented once.
- Stack is circular: the 9th push overwrites the oldest entry; a pop from empty returns whatever entry sp−1 indexes. This is PIC16F behaviour, not an error.
- Strobes are not qualified internally by Q phase; the decoder guarantees its own sequencing.

## Timing
- All state updates occur at the rising edge of `clk`. No combinational path from strobes to outputs.
- `prog_addr` and `instr_current` are registered outputs.
- Normal fetch: `instr_rd_en`=`incr_pc_en`=1 in one cycle. At that edge IR ← mem[PC] and PC ← PC+1. The new `instr_current` is visible the next cycle.
- Branch (GOTO/CALL/RETURN): `pc_load_en` or `stack_pop_en` in one cycle. The decoder then asserts `flush_en` on the next fetch, so IR shows NOP for one instruction period (8-cycle branch).
- Reset mid-operation: reset overrides all strobes at the same edge.

## Configuration
- `STACK_ERR_FLAGS_EN` defined:
  - A 4-bit depth counter (0..8) tracks the stack.
  - Push at depth 8 sets `stack_overflow`; depth saturates at 8.
  - Pop at depth 0 sets `stack_underflow`; depth stays 0.
  - Both flags are sticky until reset.
  - Push+pop in the same cycle acts as a pop for the depth counter.
- `STACK_ERR_FLAGS_EN` not defined:
  - No depth counter.
  - Both flag outputs are tied to 0.
  - Stack behaviour is otherwise identical.

## Test plan
- Reset, then memory holds 14'h3055 at address 0; pulse `instr_rd_en`+`incr_pc_en` → `instr_current`=14'h3055, `prog_addr`=1 next cycle.
- PC=13'h1FFF, pulse `incr_pc_en` → PC=13'h0000.
- PC=13'h0010, pulse `stack_push_en`+`pc_load_en` with `pc_load_val`=13'h0200 → PC=13'h0200. Later `stack_pop_en` → PC=13'h0010. A `flush_en` cycle gives `instr_current`=14'h0000.
- 9 pushes of PC values 1..9, then 8 pops → returned sequence 9,8,7,6,5,4,3,2 (entry 1 overwritten). With `STACK_ERR_FLAGS_EN`: `stack_overflow`=1 after the 9th push; one further pop → `stack_underflow`=1.
- `pclath`=5'h03, `pcl_wr_en` with `pcl_wr_data`=8'h40 and `incr_pc_en`=1 in the same cycle → PC=13'h0340.
- Assert `rst`=0 while `pc_load_en`=1 and `flush_en`=1 → PC=0, IR=0, sp=0, flags 0 at that edge.

Source files
------------

// File: rtl/pic_fetch_unit.sv
// PIC16F-compatible PC / instruction-fetch stage with an 8-level circular return stack.
// Optional macro STACK_ERR_FLAGS_EN adds sticky stack overflow/underflow flags.
module pic_fetch_unit (
   input  logic        clk,
   input  logic        rst,
   output logic [12:0] prog_addr,
   input  logic [13:0] prog_rd_data,
   input  logic        instr_rd_en,
   input  logic        incr_pc_en,
   input  logic        flush_en,
   input  logic        pc_load_en,
   input  logic [12:0] pc_load_val,
   input  logic        pcl_wr_en,
   input  logic [7:0]  pcl_wr_data,
   input  logic [4:0]  pclath,
   input  logic        stack_push_en,
   input  logic        stack_pop_en,
   output logic [13:0] instr_current,
   output logic        stack_overflow,
   output logic        stack_underflow
);

   logic [12:0] pc_q, pc_d;
   logic [13:0] ir_q, ir_d;
   logic [2:0]  sp_q, sp_d;
   logic [12:0] stack_q [8];
   logic [12:0] stack_d [8];
   logic [12:0] tos_s;
   logic        push_s;

   // A pop in the same cycle as a push cancels the push entirely.
   assign push_s = stack_push_en & ~stack_pop_en;
   assign tos_s  = stack_q[sp_q - 3'd1];

   // Next-state for PC, IR, stack pointer and stack contents.
   always_comb begin
      pc_d    = pc_q;
      ir_d    = ir_q;
      sp_d    = sp_q;
      stack_d = stack_q;

      if (flush_en) begin
         ir_d = 14'h0000;
      end else if (instr_rd_en) begin
         ir_d = prog_rd_data;
      end else begin
         ir_d = ir_q;
      end

      if (stack_pop_en) begin
         pc_d = tos_s;
      end else if (pc_load_en) begin
         pc_d = pc_load_val;
      end else if (pcl_wr_en) begin
         pc_d = {pclath, pcl_wr_data};
      end else if (incr_pc_en) begin
         pc_d = pc_q + 13'd1;
      end else begin
         pc_d = pc_q;
      end

      if (stack_pop_en) begin
         sp_d = sp_q - 3'd1;
      end else if (push_s) begin
         stack_d[sp_q] = pc_q;
         sp_d          = sp_q + 3'd1;
      end else begin
         sp_d = sp_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q <= 13'h0000;
         ir_q <= 14'h0000;
         sp_q <= 3'd0;
         for (int i = 0; i < 8; i++) begin
            stack_q[i] <= 13'h0000;
         end
      end else begin
         pc_q <= pc_d;
         ir_q <= ir_d;
         sp_q <= sp_d;
         for (int i = 0; i < 8; i++) begin
            stack_q[i] <= stack_d[i];
         end
      end
   end

   assign prog_addr     = pc_q;
   assign instr_current = ir_q;

`ifdef STACK_ERR_FLAGS_EN
   logic [3:0] depth_q, depth_d;
   logic       ovf_q, ovf_d;
   logic       unf_q, unf_d;

   // Depth tracking saturates at 0 and 8; hitting either limit sets a sticky flag.
   always_comb begin
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (stack_pop_en) begin
         if (depth_q == 4'd0) begin
            unf_d = 1'b1;
         end else begin
            depth_d = depth_q - 4'd1;
         end
      end else if (stack_push_en) begin
         if (depth_q == 4'd8) begin
            ovf_d = 1'b1;
         end else begin
            depth_d = depth_q + 4'd1;
         end
      end else begin
         depth_d = depth_q;
      end
   end

   // Error-flag registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         depth_q <= 4'd0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign stack_overflow  = ovf_q;
   assign stack_underflow = unf_q;
`else
   assign stack_overflow  = 1'b0;
   assign stack_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pic_fetch_unit.sv
// Directed self-checking bench for pic_fetch_unit.
// Flag expectations follow whether STACK_ERR_FLAGS_EN is defined for the build.
module tb_pic_fetch_unit;

`ifdef STACK_ERR_FLAGS_EN
   localparam bit FLAGS_EN = 1'b1;
`else
   localparam bit FLAGS_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [12:0] prog_addr;
   logic [13:0] prog_rd_data;
   logic        instr_rd_en;
   logic        incr_pc_en;
   logic        flush_en;
   logic        pc_load_en;
   logic [12:0] pc_load_val;
   logic        pcl_wr_en;
   logic [7:0]  pcl_wr_data;
   logic [4:0]  pclath;
   logic        stack_push_en;
   logic        stack_pop_en;
   logic [13:0] instr_current;
   logic        stack_overflow;
   logic        stack_underflow;

   int n_checks;
   int n_fail;

   pic_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .prog_addr      (prog_addr),
      .prog_rd_data   (prog_rd_data),
      .instr_rd_en    (instr_rd_en),
      .incr_pc_en     (incr_pc_en),
      .flush_en       (flush_en),
      .pc_load_en     (pc_load_en),
      .pc_load_val    (pc_load_val),
      .pcl_wr_en      (pcl_wr_en),
      .pcl_wr_data    (pcl_wr_data),
      .pclath         (pclath),
      .stack_push_en  (stack_push_en),
      .stack_pop_en   (stack_pop_en),
      .instr_current  (instr_current),
      .stack_overflow (stack_overflow),
      .stack_underflow(stack_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program memory: address 0 holds 14'h3055, elsewhere a pattern derived from the address.
   assign prog_rd_data = (prog_addr == 13'h0000) ? 14'h3055 : ({1'b0, prog_addr} ^ 14'h2A00);

   task automatic idle();
      instr_rd_en   = 1'b0;
      incr_pc_en    = 1'b0;
      flush_en      = 1'b0;
      pc_load_en    = 1'b0;
      pc_load_val   = 13'h0000;
      pcl_wr_en     = 1'b0;
      pcl_wr_data   = 8'h00;
      pclath        = 5'h00;
      stack_push_en = 1'b0;
      stack_pop_en  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (prog_addr !== 13'h0000) begin
         n_fail++; $display("FAIL reset_pc got %h want %h", prog_addr, 13'h0000);
      end
      n_checks++;
      if (instr_current !== 14'h0000) begin
         n_fail++; $display("FAIL reset_ir got %h want %h", instr_current, 14'h0000);
      end
      n_checks++;
      if ({stack_overflow, stack_underflow} !== 2'b00) begin
         n_fail++; $display("FAIL reset_flags got %b want 00", {stack_overflow, stack_underflow});
      end
   endtask

   task automatic test_fetch();
      instr_rd_en = 1'b1; incr_pc_en = 1'b1;
      tick();
      n_checks++;
      if (instr_current !== 14'h3055) begin
         n_fail++; $display("FAIL fetch0_ir got %h want %h", instr_current, 14'h3055);
      end
      n_checks++;
      if (prog_addr !== 13'h0001) begin
         n_fail++; $display("FAIL fetch0_pc got %h want %h", prog_addr, 13'h0001);
      end
      instr_rd_en = 1'b1; incr_pc_en = 1'b1;
      tick();
      n_checks++;
      if (instr_current !== 14'h2A01 || prog_addr !== 13'h0002) begin
         n_fail++; $display("FAIL fetch1 got ir=%h pc=%h want ir=2a01 pc=0002", instr_current, prog_addr);
      end
      // Hold: no strobes, state must not move.
      tick();
      n_checks++;
      if (instr_current !== 14'h2A01 || prog_addr !== 13'h0002) begin
         n_fail++; $display("FAIL hold got ir=%h pc=%h want ir=2a01 pc=0002", instr_current, prog_addr);
      end
   endtask

   task automatic test_wrap();
      pc_load_en = 1'b1; pc_load_val = 13'h1FFF;
      tick();
      n_checks++;
      if (prog_addr !== 13'h1FFF) begin
         n_fail++; $display("FAIL load_1fff got %h want %h", prog_addr, 13'h1FFF);
      end
      incr_pc_en = 1'b1;
      tick();
      n_checks++;
      if (prog_addr !== 13'h0000) begin
         n_fail++; $display("FAIL pc_wrap got %h want %h", prog_addr, 13'h0000);
      end
   endtask

   task automatic test_call_return();
      pc_load_en = 1'b1; pc_load_val = 13'h0010;
      tick();
      stack_push_en = 1'b1; pc_load_en = 1'b1; pc_load_val = 13'h0200;
      tick();
      n_checks++;
      if (prog_addr !== 13'h0200) begin
         n_fail++; $display("FAIL call_pc got %h want %h", prog_addr, 13'h0200);
      end
      instr_rd_en = 1'b1; incr_pc_en = 1'b1;
      tick();
      instr_rd_en = 1'b1; incr_pc_en = 1'b1;
      tick();
      n_checks++;
      if (instr_current !== 14'h2801 || prog_addr !== 13'h0202) begin
         n_fail++; $display("FAIL sub_fetch got ir=%h pc=%h want ir=2801 pc=0202", instr_current, prog_addr);
      end
      stack_pop_en = 1'b1;
      tick();
      n_checks++;
      if (prog_addr !== 13'h0010) begin
         n_fail++; $display("FAIL return_pc got %h want %h", prog_addr, 13'h0010);
      end
      // Flush wins over a simultaneous instruction read.
      flush_en = 1'b1; instr_rd_en = 1'b1; incr_pc_en = 1'b1;
      tick();
      n_checks++;
      if (instr_current !== 14'h0000 || prog_addr !== 13'h0011) begin
         n_fail++; $display("FAIL flush got ir=%h pc=%h want ir=0000 pc=0011", instr_current, prog_addr);
      end
   endtask

   task automatic test_stack_circular();
      logic [12:0] exp_pc;
      do_reset();
      pc_load_en = 1'b1; pc_load_val = 13'h0001;
      tick();
      for (int i = 0; i < 9; i++) begin
         stack_push_en = 1'b1; incr_pc_en = 1'b1;
         tick();
      end
      n_checks++;
      if (prog_addr !== 13'h000A) begin
         n_fail++; $display("FAIL push9_pc got %h want %h", prog_addr, 13'h000A);
      end
      n_checks++;
      if (stack_overflow !== FLAGS_EN) begin
         n_fail++; $display("FAIL overflow got %b want %b", stack_overflow, FLAGS_EN);
      end
      for (int i = 0; i < 8; i++) begin
         exp_pc = 13'd9 - 13'(i);
         stack_pop_en = 1'b1;
         tick();
         n_checks++;
         if (prog_addr !== exp_pc) begin
            n_fail++; $display("FAIL pop%0d got %h want %h", i, prog_addr, exp_pc);
         end
      end
      n_checks++;
      if (stack_underflow !== 1'b0) begin
         n_fail++; $display("FAIL underflow_early got %b want 0", stack_underflow);
      end
      stack_pop_en = 1'b1;
      tick();
      n_checks++;
      if (stack_underflow !== FLAGS_EN || prog_addr !== 13'h0009) begin
         n_fail++; $display("FAIL underflow got uf=%b pc=%h want uf=%b pc=0009", stack_underflow, prog_addr, FLAGS_EN);
      end
   endtask

   task automatic test_push_pop_same();
      do_reset();
      pc_load_en = 1'b1; pc_load_val = 13'h0100;
      tick();
      stack_push_en = 1'b1; pc_load_en = 1'b1; pc_load_val = 13'h0300;
      tick();
      // Simultaneous push+pop: pop returns 0100, push of 0300 discarded.
      stack_push_en = 1'b1; stack_pop_en = 1'b1;
      tick();
      n_checks++;
      if (prog_addr !== 13'h0100) begin
         n_fail++; $display("FAIL pushpop_pc got %h want %h", prog_addr, 13'h0100);
      end
      // sp back at 0: next pop reads entry 7, still the reset value.
      stack_pop_en = 1'b1;
      tick();
      n_checks++;
      if (prog_addr !== 13'h0000) begin
         n_fail++; $display("FAIL pushpop_sp got %h want %h", prog_addr, 13'h0000);
      end
   endtask

   task automatic test_pcl_write();
      pclath = 5'h03; pcl_wr_en = 1'b1; pcl_wr_data = 8'h40; incr_pc_en = 1'b1;
      tick();
      n_checks++;
      if (prog_addr !== 13'h0340) begin
         n_fail++; $display("FAIL pcl_write got %h want %h", prog_addr, 13'h0340);
      end
      // pc_load outranks PCL write.
      pclath = 5'h1F; pcl_wr_en = 1'b1; pcl_wr_data = 8'hFF; pc_load_en = 1'b1; pc_load_val = 13'h0ABC;
      tick();
      n_checks++;
      if (prog_addr !== 13'h0ABC) begin
         n_fail++; $display("FAIL load_over_pcl got %h want %h", prog_addr, 13'h0ABC);
      end
   endtask

   task automatic test_reset_mid();
      stack_push_en = 1'b1; instr_rd_en = 1'b1; incr_pc_en = 1'b1;
      tick();
      rst = 1'b0; pc_load_en = 1'b1; pc_load_val = 13'h1234; flush_en = 1'b1;
      tick();
      rst = 1'b1;
      n_checks++;
      if (prog_addr !== 13'h0000 || instr_current !== 14'h0000) begin
         n_fail++; $display("FAIL reset_mid got pc=%h ir=%h want 0000/0000", prog_addr, instr_current);
      end
      n_checks++;
      if ({stack_overflow, stack_underflow} !== 2'b00) begin
         n_fail++; $display("FAIL reset_mid_flags got %b want 00", {stack_overflow, stack_underflow});
      end
      // Reset cleared the stack: a pop returns 0.
      pc_load_en = 1'b1; pc_load_val = 13'h0777;
      tick();
      stack_pop_en = 1'b1;
      tick();
      n_checks++;
      if (prog_addr !== 13'h0000) begin
         n_fail++; $display("FAIL reset_stack got %h want %h", prog_addr, 13'h0000);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      idle();
      test_reset();
      test_fetch();
      test_wrap();
      test_call_return();
      test_stack_circular();
      test_push_pop_same();
      test_pcl_write();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
